// File: rtl/ram_seq_ctrl_if.sv
// Signal bundle between ram_seq_ctrl and its request source, data generator, RAM and consumer.
// Pure wiring, no latency; o_err exists only when RAM_SEQ_CTRL_CHECK_EN is defined.
// No backpressure: every o_* is owned by the controller, every i_* by the environment.
interface ram_seq_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
);
    logic              i_tx_req;
    logic              o_gen_start;
    logic              i_gen_valid;
    logic [31:0]       i_gen_data;
    logic              o_ram_we;
    logic              o_ram_re;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [31:0]       o_ram_wdata;
    logic [31:0]       i_ram_rdata;
    logic              o_rd_valid;
    logic [31:0]       o_rd_data;
    logic              o_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_pkt_count;
`ifdef RAM_SEQ_CTRL_CHECK_EN
    logic              o_err;

    modport master (
        input  i_tx_req, i_gen_valid, i_gen_data, i_ram_rdata,
        output o_gen_start, o_ram_we, o_ram_re, o_ram_addr, o_ram_wdata,
               o_rd_valid, o_rd_data, o_busy, o_done, o_pkt_count, o_err
    );
    modport slave (
        output i_tx_req, i_gen_valid, i_gen_data, i_ram_rdata,
        input  o_gen_start, o_ram_we, o_ram_re, o_ram_addr, o_ram_wdata,
               o_rd_valid, o_rd_data, o_busy, o_done, o_pkt_count, o_err
    );
`else
    modport master (
        input  i_tx_req, i_gen_valid, i_gen_data, i_ram_rdata,
        output o_gen_start, o_ram_we, o_ram_re, o_ram_addr, o_ram_wdata,
               o_rd_valid, o_rd_data, o_busy, o_done, o_pkt_count
    );
    modport slave (
        output i_tx_req, i_gen_valid, i_gen_data, i_ram_rdata,
        input  o_gen_start, o_ram_we, o_ram_re, o_ram_addr, o_ram_wdata,
               o_rd_valid, o_rd_data, o_busy, o_done, o_pkt_count
    );
`endif
endinterface

// File: rtl/ram_seq_ctrl.sv
// Packet sequencer: start generator, write PKT_LEN words to RAM, read them back; RAM_SEQ_CTRL_CHECK_EN adds readback check.
// Latency: start 1 clk after request, done PKT_LEN*2+RD_LAT+3 clks after request with contiguous valids.
// Backpressure: generator stalls hold the write counter; reads are never stalled.
module ram_seq_ctrl #(
    parameter int PKT_LEN = 64,
    parameter int ADDR_W  = 6,
    parameter int RD_LAT  = 1,
    parameter int CNT_W   = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ram_seq_ctrl_if.master bus
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [2:0]        drn_cnt_q, drn_cnt_d;
    logic              gen_start_q, gen_start_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic [31:0]       rd_hold_q;
    logic              rd_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            drn_cnt_q   <= '0;
            gen_start_q <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            gen_start_q <= gen_start_d;
            we_q        <= we_d;
            re_q        <= re_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Outputs are registered from next-state decode, so each takes effect the cycle after its cause.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        gen_start_d = 1'b0;
        we_d        = 1'b0;
        re_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_tx_req) begin
                    state_d     = S_START;
                    gen_start_d = 1'b1;
                end
            end
            S_START: begin
                state_d  = S_WRITE;
                wr_cnt_d = '0;
            end
            S_WRITE: begin
                if (bus.i_gen_valid) begin
                    we_d     = 1'b1;
                    addr_d   = wr_cnt_q[ADDR_W-1:0];
                    wdata_d  = bus.i_gen_data;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST) begin
                        state_d  = S_READ;
                        rd_cnt_d = '0;
                    end
                end
            end
            S_READ: begin
                re_d     = 1'b1;
                addr_d   = rd_cnt_q[ADDR_W-1:0];
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST) begin
                    state_d   = S_DRAIN;
                    drn_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == 3'(RD_LAT)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                end else begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pipe_q <= '0;
            rd_hold_q <= '0;
        end else begin
            rd_pipe_q[0] <= re_q;
            for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
            if (rd_vld) rd_hold_q <= bus.i_ram_rdata;
        end
    end

    assign rd_vld = rd_pipe_q[RD_LAT-1];

    // RAM data arrives in the same cycle as o_rd_valid, so it bypasses the hold register.
    assign bus.o_rd_data   = rd_vld ? bus.i_ram_rdata : rd_hold_q;
    assign bus.o_rd_valid  = rd_vld;
    assign bus.o_gen_start = gen_start_q;
    assign bus.o_ram_we    = we_q;
    assign bus.o_ram_re    = re_q;
    assign bus.o_ram_addr  = addr_q;
    assign bus.o_ram_wdata = wdata_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_pkt_count = pkt_cnt_q;

`ifdef RAM_SEQ_CTRL_CHECK_EN
    logic [31:0] seed_q;
    logic [31:0] chk_idx_q;
    logic        err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seed_q    <= '0;
            chk_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == S_WRITE && bus.i_gen_valid && wr_cnt_q == '0) seed_q <= bus.i_gen_data;
            if (state_q == S_START)  chk_idx_q <= '0;
            else if (rd_vld)         chk_idx_q <= chk_idx_q + 1'b1;
            if (rd_vld && bus.i_ram_rdata != seed_q + chk_idx_q) err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`endif
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with a scoreboard fed by the generator model.
// RAM model has 1-clk read latency; define RAM_SEQ_CTRL_CHECK_EN to also exercise o_err.
module tb_ram_seq_ctrl;
    localparam int PKT_LEN = 64;
    localparam int ADDR_W  = 6;
    localparam int RD_LAT  = 1;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_seq_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

    ram_seq_ctrl #(.PKT_LEN(PKT_LEN), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM model; corrupt_en flips bit 0 of the word read from address 10
    logic [31:0] mem [0:PKT_LEN-1];
    logic [31:0] rdata_q = '0;
    bit          corrupt_en = 1'b0;
    always @(posedge clk) begin
        if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
        if (bus.o_ram_re)
            rdata_q <= mem[bus.o_ram_addr] ^ ((corrupt_en && bus.o_ram_addr == 6'd10) ? 32'h1 : 32'h0);
    end
    assign bus.i_ram_rdata = rdata_q;

    // Generator model: pushes each emitted word as the expected readback
    logic [31:0] exp_q[$];
    logic [31:0] gen_next = '0;
    int          stall_at = 0;
    int          stall_len = 0;

    initial begin : gen
        bus.i_gen_valid = 1'b0;
        bus.i_gen_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.o_gen_start) begin
                for (int i = 0; i < PKT_LEN; i++) begin
                    if (i == stall_at && stall_len > 0)
                        for (int s = 0; s < stall_len; s++) begin
                            @(posedge clk); #1;
                            bus.i_gen_valid = 1'b0;
                        end
                    @(posedge clk); #1;
                    bus.i_gen_valid = 1'b1;
                    bus.i_gen_data  = gen_next;
                    exp_q.push_back(gen_next);
                    gen_next++;
                end
                @(posedge clk); #1;
                bus.i_gen_valid = 1'b0;
            end
        end
    end

    // Monitor: address sequencing, we/re exclusion, readback scoreboard
    int          wr_exp = 0;
    int          rd_exp = 0;
    int          rd_idx = 0;
    bit          err_pend = 1'b0;
    logic [31:0] exp_word;

    always @(negedge clk) begin
        if (bus.o_gen_start) begin
            wr_exp = 0;
            rd_exp = 0;
            rd_idx = 0;
        end
        if (bus.o_ram_we) begin
            check("wr_addr", bus.o_ram_addr, wr_exp);
            check("we_re_excl", bus.o_ram_re, 0);
            wr_exp++;
        end
        if (bus.o_ram_re) begin
            check("rd_addr", bus.o_ram_addr, rd_exp);
            rd_exp++;
        end
`ifdef RAM_SEQ_CTRL_CHECK_EN
        if (err_pend) begin
            check("err_rise", bus.o_err, 1);
            err_pend = 1'b0;
        end
`endif
        if (bus.o_rd_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_unexpected: got data %0h expected no valid (cycle %0d)", bus.o_rd_data, cyc);
            end else begin
                exp_word = exp_q.pop_front();
                if (corrupt_en && rd_idx == 10) exp_word = exp_word ^ 32'h1;
                check("rd_data", bus.o_rd_data, exp_word);
`ifdef RAM_SEQ_CTRL_CHECK_EN
                if (corrupt_en && rd_idx == 10) begin
                    check("err_before", bus.o_err, 0);
                    err_pend = 1'b1;
                end
`endif
            end
            rd_idx++;
        end
    end

    bit exp_err = 1'b0;

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      bus.o_busy, 0);
        check({tag, "_done"},      bus.o_done, 0);
        check({tag, "_gen_start"}, bus.o_gen_start, 0);
        check({tag, "_we"},        bus.o_ram_we, 0);
        check({tag, "_re"},        bus.o_ram_re, 0);
        check({tag, "_addr"},      bus.o_ram_addr, 0);
        check({tag, "_wdata"},     bus.o_ram_wdata, 0);
        check({tag, "_rd_valid"},  bus.o_rd_valid, 0);
        check({tag, "_rd_data"},   bus.o_rd_data, 0);
        check({tag, "_pkt_count"}, bus.o_pkt_count, 0);
`ifdef RAM_SEQ_CTRL_CHECK_EN
        check({tag, "_err"},       bus.o_err, 0);
`endif
    endtask

    task automatic run_packet(input bit hold, input int extra, input int exp_cnt);
        int c0, starts, dc;
        bit got;
        @(posedge clk); #1;
        bus.i_tx_req = 1'b1;
        c0 = cyc;
        if (!hold) begin
            @(posedge clk); #1;
            bus.i_tx_req = 1'b0;
        end
        starts = 0;
        got = 1'b0;
        dc = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (bus.o_gen_start) starts++;
            if (bus.o_done) begin
                got = 1'b1;
                dc = cyc;
            end
        end
        bus.i_tx_req = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no o_done in 400 cycles expected one at +%0d", 132 + extra);
        end else begin
            check("done_cycle", dc - c0, 132 + extra);
            check("gen_start_count", starts, 1);
            check("pkt_count", bus.o_pkt_count, exp_cnt);
            check("busy_at_done", bus.o_busy, 1);
`ifdef RAM_SEQ_CTRL_CHECK_EN
            check("err_level", bus.o_err, exp_err);
`endif
        end
    endtask

    initial begin : main
        bit found;
        bus.i_tx_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // single packet, then RAM contents
        run_packet(1'b0, 0, 1);
        for (int i = 0; i < PKT_LEN; i++) check("ram_word", mem[i], i);

        // back-to-back request the cycle after o_done
        run_packet(1'b0, 0, 2);

        // request held high through WRITE and READ
        run_packet(1'b1, 0, 3);

        // 5-cycle generator gap after word 20
        stall_at  = 21;
        stall_len = 5;
        run_packet(1'b0, 5, 4);
        stall_len = 0;

        // reset during READ at address 30
        @(posedge clk); #1;
        bus.i_tx_req = 1'b1;
        @(posedge clk); #1;
        bus.i_tx_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (bus.o_ram_re && bus.o_ram_addr == 6'd30) found = 1'b1;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL rd30_timeout: got no read at address 30 expected one within 400 cycles");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", bus.o_done, 0);
        end
        run_packet(1'b0, 0, 1);

`ifdef RAM_SEQ_CTRL_CHECK_EN
        corrupt_en = 1'b1;
        exp_err    = 1'b1;
        run_packet(1'b0, 0, 2);
        @(negedge clk);
        check("err_sticky", bus.o_err, 1);
        corrupt_en = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
